// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between two requesters.
// Operands are registered toward the ALU. Multiply is held for MUL_CYCLES cycles before the result is captured.
module alu_arbiter #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_result,
    output logic        rsp1_zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [2:0] CNT_MUL = 3'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        owner_reg;
    logic        last_grant_reg;
    logic [2:0]  cnt_reg;
    logic [15:0] alu_a_reg, alu_b_reg;
    logic [3:0]  alu_control_reg;

    logic [1:0]  req_valid, req_ready, rsp_ready, rsp_valid;
    logic [15:0] req_a [2];
    logic [15:0] req_b [2];
    logic [3:0]  req_op [2];
    logic [15:0] rsp_result_reg [2];
    logic [1:0]  rsp_zero_reg;
    logic        winner, accept, capture, take;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    always_comb begin
        state_next = state_reg;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        accept     = 1'b0;
        capture    = 1'b0;
        take       = 1'b0;
        // On a contest the requester that did not win last time goes first.
        if (req_valid == 2'b11) begin
            winner = ~last_grant_reg;
        end else begin
            winner = ~req_valid[0];
        end
        case (state_reg)
            IDLE: begin
                if (req_valid[winner]) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_next        = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg == 3'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_reg] = 1'b1;
                if (rsp_ready[owner_reg]) begin
                    take       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            req_ready = 2'b00;
            rsp_valid = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            cnt_reg         <= 3'd0;
            alu_a_reg       <= 16'd0;
            alu_b_reg       <= 16'd0;
            alu_control_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                alu_a_reg       <= req_a[winner];
                alu_b_reg       <= req_b[winner];
                alu_control_reg <= req_op[winner];
                owner_reg       <= winner;
                cnt_reg         <= (req_op[winner] == OP_MUL) ? CNT_MUL : 3'd0;
            end else if (state_reg == EXEC && cnt_reg != 3'd0) begin
                cnt_reg <= cnt_reg - 3'd1;
            end
            if (take) begin
                last_grant_reg <= owner_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk) begin
                if (reset) begin
                    rsp_result_reg[gi] <= 16'd0;
                    rsp_zero_reg[gi]   <= 1'b0;
                end else if (capture && owner_reg == 1'(gi)) begin
                    rsp_result_reg[gi] <= alu_result;
                    rsp_zero_reg[gi]   <= alu_zero;
                end
            end
        end
    endgenerate

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result_reg[0];
    assign rsp1_result = rsp_result_reg[1];
    assign rsp0_zero   = rsp_zero_reg[0];
    assign rsp1_zero   = rsp_zero_reg[1];
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_control = alu_control_reg;
    assign busy        = ~reset && (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, directed scenarios, then random traffic
// checked against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;

    localparam int MUL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_zero;
    logic        rsp1_valid, rsp1_ready, rsp1_zero;
    logic [15:0] rsp0_result, rsp1_result;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero, busy;

    int total = 0;
    int bad   = 0;

    logic        pv  [2];
    logic [15:0] pa  [2];
    logic [15:0] pb  [2];
    logic [3:0]  pop [2];
    int          last_grant_m;

    alu_arbiter #(.MUL_CYCLES(MUL)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return 16'((32'(a) * 32'(b)) & 32'hFFFF);
            4'b0011: return a & b;
            4'b0100: return a | b;
            4'b0101: return a ^ b;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_a, alu_b, alu_control);
        alu_zero   = (alu_result == 16'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
        req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
    endtask

    task automatic set_req(input int p, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op);
        pv[p] = 1'b1; pa[p] = a; pb[p] = b; pop[p] = op;
    endtask

    // Serves one transaction from the pending requests; h = cycles the owner stalls rsp_ready.
    task automatic serve(input int h, input bit stray, output int w);
        int L;
        logic [15:0] er, ea, eb;
        logic [3:0]  eo;
        logic        ez;
        drive_inputs();
        #1;
        if (pv[0] && pv[1]) w = (last_grant_m == 1) ? 0 : 1;
        else w = pv[0] ? 0 : 1;
        chk("ready0_idle", req0_ready, w == 0);
        chk("ready1_idle", req1_ready, w == 1);
        chk("busy_idle", busy, 0);
        chk("rspv_idle", {rsp1_valid, rsp0_valid}, 0);
        ea = pa[w]; eb = pb[w]; eo = pop[w];
        L  = (eo == 4'b0010) ? MUL : 1;
        er = alu_f(ea, eb, eo);
        ez = (er == 16'd0);
        @(posedge clk); #1;
        pv[w] = 1'b0;
        drive_inputs();
        for (int k = 1; k <= L; k++) begin
            #1;
            chk("busy_exec", busy, 1);
            chk("rspv_exec", {rsp1_valid, rsp0_valid}, 0);
            chk("ready_exec", {req1_ready, req0_ready}, 0);
            chk("alu_ctl_exec", alu_control, eo);
            chk("alu_ab_exec", {alu_a, alu_b}, {ea, eb});
            @(posedge clk); #1;
        end
        for (int j = 0; j <= h; j++) begin
            rsp0_ready = (w == 0) ? (j == h) : (stray && j < h);
            rsp1_ready = (w == 1) ? (j == h) : (stray && j < h);
            #1;
            chk("rspv_resp", {rsp1_valid, rsp0_valid}, (w == 0) ? 2'b01 : 2'b10);
            chk("result", (w == 0) ? rsp0_result : rsp1_result, er);
            chk("zero", (w == 0) ? rsp0_zero : rsp1_zero, ez);
            chk("busy_resp", busy, 1);
            chk("ready_resp", {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        last_grant_m = w;
        #1;
        chk("rspv_after", {rsp1_valid, rsp0_valid}, 0);
        $display("txn port=%0d op=%h a=%h b=%h lat=%0d hold=%0d result=%h zero=%0d",
                 w, eo, ea, eb, L, h, er, ez);
    endtask

    initial begin
        int w;
        int exp_grant [4];
        exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0; exp_grant[3] = 1;
        last_grant_m = 1;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b1; pa[p] = 16'h0001; pb[p] = 16'h0001; pop[p] = 4'b0000;
        end
        drive_inputs();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        reset = 1'b1;

        // Reset cycle with both valids high: everything must stay quiet.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_rspv", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_a, alu_b, alu_control}, 0);
        chk("rst_rsp", {rsp0_result, rsp1_result}, 0);
        chk("rst_zero", {rsp1_zero, rsp0_zero}, 0);
        pv[0] = 1'b0; pv[1] = 1'b0;
        drive_inputs();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        set_req(0, 16'h0005, 16'h0003, 4'b0000);
        serve(0, 1'b0, w);
        chk("single_res", rsp0_result, 16'h0008);

        set_req(1, 16'h1234, 16'h1234, 4'b0001);
        serve(3, 1'b1, w);
        chk("zero_res", {rsp1_zero, rsp1_result}, {1'b1, 16'h0000});

        set_req(0, 16'h0010, 16'h0020, 4'b0010);
        serve(0, 1'b0, w);
        chk("mul_res", rsp0_result, 16'h0200);

        // Reset during the second EXEC cycle of a multiply drops it.
        set_req(1, 16'h0003, 16'h0004, 4'b0010);
        drive_inputs();
        #1;
        chk("rm_ready1", req1_ready, 1);
        @(posedge clk); #1;
        pv[1] = 1'b0;
        drive_inputs();
        #1;
        chk("rm_busy_exec", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rm_busy_rst", busy, 0);
        chk("rm_rspv_rst", {rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rm_alu_clr", {alu_a, alu_b, alu_control}, 0);
        chk("rm_rsp_clr", {rsp0_result, rsp1_zero}, 0);
        for (int k = 0; k < 5; k++) begin
            chk("rm_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
            @(posedge clk); #1;
        end
        last_grant_m = 1;

        // Both requesters keep an add pending: grants must alternate starting with req0.
        for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p]) set_req(p, 16'(t * 16 + p), 16'(100 + t), 4'b0000);
            end
            serve(t % 2, 1'b0, w);
            chk("rr_grant", w, exp_grant[t]);
        end
        pv[0] = 1'b0;
        pv[1] = 1'b0;

        set_req(1, 16'h0002, 16'h0003, 4'b1111);
        serve(1, 1'b0, w);
        chk("illegal_res", rsp1_result, 16'h0005);

        for (int t = 0; t < 30; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom_range(0, 1) == 1))
                    set_req(p, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
            end
            if (!pv[0] && !pv[1])
                set_req(t % 2, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                        4'($urandom_range(0, 2)));
            serve(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
